// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two combinational read ports,
// two write ports (port B wins on an address collision), an architectural
// zero at entry 0, and a sequential clear engine shared by reset and clr.
// Optional same-cycle write-to-read forwarding is enabled by defining the
// macro REGFILE_BYPASS_EN; the default build returns array contents only.
module regfile_mp #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   output logic            busy,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] data1,
   output logic [XLEN-1:0] data2,
   input  logic [AW-1:0]   rd_a,
   input  logic [AW-1:0]   rd_b,
   input  logic [XLEN-1:0] wr_data_a,
   input  logic [XLEN-1:0] wr_data_b,
   input  logic            wr_en_a,
   input  logic            wr_en_b
);

   localparam int NREG = 2 ** AW;
   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
   localparam logic [AW-1:0] FIRST_IDX = AW'(1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [AW-1:0]   r_cnt;
   logic [AW-1:0]   w_cnt_next;
   logic            w_clr_we;
   logic            w_we_a;
   logic            w_we_b;

   // Entry 0 has no storage; it is synthesised as a constant zero on read.
   logic [XLEN-1:0] r_mem [1:NREG-1];

   // Read-port addresses gathered into a vector so both ports share one
   // generated datapath.
   logic [1:0][AW-1:0]   w_rs;
   logic [1:0][XLEN-1:0] w_rdata;

   // State and clear-counter register; reset restarts the clear sequence
   // from entry 1 no matter where it was.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_CLEAR;
         r_cnt   <= FIRST_IDX;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic: IDLE accepts clr, CLEAR walks entries 1..NREG-1 and
   // ignores clr until the last entry has been zeroed.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_clr_we     = 1'b0;
      busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clr) begin
               w_state_next = S_CLEAR;
               w_cnt_next   = FIRST_IDX;
            end
         end
         S_CLEAR: begin
            busy       = 1'b1;
            w_clr_we   = ~rst;
            w_cnt_next = r_cnt + FIRST_IDX;
            if (r_cnt == LAST_IDX) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // User write qualification: blocked during clear, during reset, and for
   // the architectural-zero address.
   always_comb begin
      w_we_a = wr_en_a & ~busy & ~rst & (rd_a != '0);
      w_we_b = wr_en_b & ~busy & ~rst & (rd_b != '0);
   end

   // Storage update. Clear writes and user writes are mutually exclusive
   // because user writes are gated by busy; port B is written last so it
   // overrides port A when both hit the same entry.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_cnt] <= '0;
      end else begin
         if (w_we_a) begin
            r_mem[rd_a] <= wr_data_a;
         end
         if (w_we_b) begin
            r_mem[rd_b] <= wr_data_b;
         end
      end
   end

   // Combinational read of one port: zero while clearing or for address 0,
   // otherwise array contents, optionally overridden by a same-cycle write.
   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
      logic [XLEN-1:0] v;
      v = '0;
      if (!busy && (addr != '0)) begin
         v = r_mem[addr];
`ifdef REGFILE_BYPASS_EN
         if (wr_en_a && (rd_a == addr)) begin
            v = wr_data_a;
         end
         if (wr_en_b && (rd_b == addr)) begin
            v = wr_data_b;
         end
`endif
      end
      return v;
   endfunction

   assign w_rs[0] = rs1;
   assign w_rs[1] = rs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         assign w_rdata[gi] = read_port(w_rs[gi]);
      end
   endgenerate

   assign data1 = w_rdata[0];
   assign data2 = w_rdata[1];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus with a cycle-tagged scoreboard. The
// stimulus pushes expectations (output select, value, cycle); a monitor on
// the falling edge pops every entry due in the current cycle and compares.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk;
   logic            rst;
   logic            clr;
   logic            busy;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] data2;
   logic [AW-1:0]   rd_a;
   logic [AW-1:0]   rd_b;
   logic [XLEN-1:0] wr_data_a;
   logic [XLEN-1:0] wr_data_b;
   logic            wr_en_a;
   logic            wr_en_b;

   regfile_mp #(.XLEN(XLEN), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .busy      (busy),
      .rs1       (rs1),
      .rs2       (rs2),
      .data1     (data1),
      .data2     (data2),
      .rd_a      (rd_a),
      .rd_b      (rd_b),
      .wr_data_a (wr_data_a),
      .wr_data_b (wr_data_b),
      .wr_en_a   (wr_en_a),
      .wr_en_b   (wr_en_b)
   );

   localparam int SEL_D1   = 0;
   localparam int SEL_D2   = 1;
   localparam int SEL_BUSY = 2;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t        e;
         logic [31:0] act;
         e = sb.pop_front();
         case (e.sel)
            SEL_D1:  act = data1;
            SEL_D2:  act = data2;
            default: act = {31'b0, busy};
         endcase
         checks++;
         if (act !== e.val) begin
            $display("FAIL %s (cycle %0d): got %h expected %h", e.name, cyc, act, e.val);
         end else begin
            passes++;
         end
         $display("check %s cycle %0d: got %h expected %h", e.name, cyc, act, e.val);
      end
   end

   task automatic expect_out(input int sel, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc;
      e.sel  = sel;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr     = 1'b0;
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
   endtask

   // Expect busy high for n cycles with data forced to zero, then low.
   task automatic expect_busy_run(input int n, input string nm);
      for (int k = 0; k < n; k++) begin
         expect_out(SEL_BUSY, 32'd1, nm);
         expect_out(SEL_D1, 32'd0, {nm, "_d1_zero"});
         step();
      end
      expect_out(SEL_BUSY, 32'd0, {nm, "_done"});
   endtask

   task automatic expect_all_zero(input string nm);
      for (int a = 1; a < 32; a++) begin
         rs1 = AW'(a);
         rs2 = AW'(32 - a);
         expect_out(SEL_D1, 32'd0, nm);
         expect_out(SEL_D2, 32'd0, nm);
         step();
      end
   endtask

   logic [31:0] exp_same;

   initial begin
      rst = 1'b1; clr = 1'b0; rs1 = '0; rs2 = '0;
      rd_a = '0; rd_b = '0; wr_data_a = '0; wr_data_b = '0;
      wr_en_a = 1'b0; wr_en_b = 1'b0;

      // Reset held for three edges keeps the counter at 1; then 31 clear edges.
      step();
      expect_out(SEL_BUSY, 32'd1, "rst_held_busy");
      step();
      expect_out(SEL_BUSY, 32'd1, "rst_held_busy");
      step();
      rst = 1'b0;
      rs1 = 5'd3;
      expect_busy_run(31, "reset_clear");
      expect_all_zero("post_reset_zero");

      // Single write to 5: bypass visibility same cycle, array next cycle.
      wr_en_a = 1'b1; rd_a = 5'd5; wr_data_a = 32'hDEADBEEF; rs1 = 5'd5;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hDEADBEEF;
`else
      exp_same = 32'h0;
`endif
      expect_out(SEL_D1, exp_same, "wr5_same_cycle");
      step();
      idle_inputs();
      expect_out(SEL_D1, 32'hDEADBEEF, "wr5_next_cycle");
      step();

      // Collision on 7: port B wins.
      wr_en_a = 1'b1; rd_a = 5'd7; wr_data_a = 32'h11;
      wr_en_b = 1'b1; rd_b = 5'd7; wr_data_b = 32'h22; rs2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'h22;
`else
      exp_same = 32'h0;
`endif
      expect_out(SEL_D2, exp_same, "collide7_same_cycle");
      step();
      idle_inputs();
      rs1 = 5'd7;
      expect_out(SEL_D1, 32'h22, "collide7_b_wins");
      step();

      // Distinct addresses both commit.
      wr_en_a = 1'b1; rd_a = 5'd3; wr_data_a = 32'h33;
      wr_en_b = 1'b1; rd_b = 5'd4; wr_data_b = 32'h44;
      step();
      idle_inputs();
      rs1 = 5'd3; rs2 = 5'd4;
      expect_out(SEL_D1, 32'h33, "dual_a_commit");
      expect_out(SEL_D2, 32'h44, "dual_b_commit");
      step();

      // Write to address 0 is discarded and disturbs nothing.
      wr_en_a = 1'b1; rd_a = 5'd0; wr_data_a = 32'hFFFFFFFF; rs1 = 5'd0;
      expect_out(SEL_D1, 32'h0, "zero_reg_same_cycle");
      step();
      idle_inputs();
      expect_out(SEL_D1, 32'h0, "zero_reg_after");
      rs2 = 5'd5;
      expect_out(SEL_D2, 32'hDEADBEEF, "zero_wr_keeps_5");
      step();
      rs1 = 5'd1; rs2 = 5'd7;
      expect_out(SEL_D1, 32'h0, "zero_wr_keeps_1");
      expect_out(SEL_D2, 32'h22, "zero_wr_keeps_7");
      step();

      // Fill every entry with A5A5A5A5.
      for (int i = 1; i <= 31; i += 2) begin
         wr_en_a = 1'b1; rd_a = AW'(i);     wr_data_a = 32'hA5A5A5A5;
         wr_en_b = 1'b1; rd_b = AW'(i + 1); wr_data_b = 32'hA5A5A5A5;
         step();
      end
      idle_inputs();
      rs1 = 5'd10; rs2 = 5'd31;
      expect_out(SEL_D1, 32'hA5A5A5A5, "fill_10");
      expect_out(SEL_D2, 32'hA5A5A5A5, "fill_31");
      step();

      // clr, then rst at clear edge 10 restarts; writes during busy ignored.
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int k = 0; k < 9; k++) begin
         expect_out(SEL_BUSY, 32'd1, "clr_busy_pre_rst");
         step();
      end
      rst = 1'b1;
      expect_out(SEL_BUSY, 32'd1, "clr_busy_at_rst");
      step();
      rst = 1'b0;
      wr_en_a = 1'b1; rd_a = 5'd20; wr_data_a = 32'h1234;
      wr_en_b = 1'b1; rd_b = 5'd30; wr_data_b = 32'h5678;
      rs1 = 5'd20;
      expect_busy_run(31, "restart_clear");
      idle_inputs();
      expect_all_zero("post_restart_zero");

      // A second clr during CLEAR does not extend the sequence.
      wr_en_a = 1'b1; rd_a = 5'd12; wr_data_a = 32'hCAFE;
      step();
      idle_inputs();
      rs1 = 5'd12;
      expect_out(SEL_D1, 32'hCAFE, "pre_clr_12");
      clr = 1'b1;
      step();
      for (int k = 0; k < 31; k++) begin
         clr = (k == 4);
         expect_out(SEL_BUSY, 32'd1, "clr_twice_busy");
         expect_out(SEL_D1, 32'd0, "clr_twice_d1_zero");
         step();
      end
      clr = 1'b0;
      expect_out(SEL_BUSY, 32'd0, "clr_twice_done");
      expect_out(SEL_D1, 32'd0, "clr_twice_12_cleared");
      step();

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && sb.size() > 0; k++) step();
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
